telemetre_ctrl: RTL and testbench

Measurement sequencer for the ultrasonic telemeter on the DE2-115. It fires the sensor trigger pulse, times the echo, and drives the cascaded BCD counter chain that displays the distance. The counter chain receives a clear pulse, one tick per centimetre and a latch strobe to the display register. A no-echo timeout and an over-range abort are included. It sits between the sensor GPIO pins and the counter and display datapath.

---
 rtl/telemetre_ctrl_if.sv | 24 ++
 rtl/telemetre_ctrl.sv | 167 ++++++++++++++++
 tb/tb_telemetre_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/telemetre_ctrl_if.sv
// Signal bundle joining the telemeter sequencer to the sensor pins and to the
// BCD counter and display chain.
interface telemetre_ctrl_if;
    logic       Start;
    logic       Auto;
    logic       Echo;
    logic       Trig;
    logic       CntClr;
    logic       CntTick;
    logic       Latch;
    logic       Timeout;
    logic       Busy;
    logic [8:0] Cm;

    modport master (
        output Start, Auto, Echo,
        input  Trig, CntClr, CntTick, Latch, Timeout, Busy, Cm
    );

    modport slave (
        input  Start, Auto, Echo,
        output Trig, CntClr, CntTick, Latch, Timeout, Busy, Cm
    );
endinterface

// File: rtl/telemetre_ctrl.sv
// Ultrasonic telemeter sequencer: fires the trigger, times the echo in centimetre ticks,
// and drives clear/tick/latch strobes to the BCD counter chain.
module telemetre_ctrl #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TICK_DIV       = 2900,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned MAX_CM         = 400,
    parameter int unsigned HOLDOFF_CYCLES = 3000000
) (
    input logic             Clk,
    input logic             Reset,
    telemetre_ctrl_if.slave bus
);
    localparam int unsigned SpanA     = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned TimerSpan = (SpanA > HOLDOFF_CYCLES) ? SpanA : HOLDOFF_CYCLES;
    localparam int unsigned TimerW    = (TimerSpan > 1) ? $clog2(TimerSpan) : 1;
    localparam int unsigned PrescW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TimerW-1:0] TrigLast    = TimerW'(TRIG_CYCLES - 1);
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [TimerW-1:0] HoldoffLast = TimerW'(HOLDOFF_CYCLES - 1);
    localparam logic [PrescW-1:0] PrescLast   = PrescW'(TICK_DIV - 1);
    // Tick is decoded one count early so the registered strobe lines up with the wrap.
    localparam logic [PrescW-1:0] TickDue     = PrescW'(TICK_DIV - 2);
    localparam logic [8:0]        MaxCm       = 9'(MAX_CM);

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitEcho,
        StMeasure,
        StHoldoff
    } stateE;

    stateE             stateQ, stateD;
    logic [TimerW-1:0] timerQ, timerD;
    logic [PrescW-1:0] prescQ, prescD;
    logic [8:0]        cmQ, cmD;
    logic [2:0]        echoShQ;
    logic              trigQ, trigD;
    logic              clrQ, clrD;
    logic              tickQ, tickD;
    logic              latchQ, latchD;
    logic              timeoutQ, timeoutD;
    logic              busyQ, busyD;
    logic              echoRise, echoFall;

    // echoShQ[1] is the synchronised echo, echoShQ[2] its previous value.
    assign echoRise = echoShQ[1] & ~echoShQ[2];
    assign echoFall = ~echoShQ[1] & echoShQ[2];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateQ   <= StIdle;
            timerQ   <= '0;
            prescQ   <= '0;
            cmQ      <= '0;
            echoShQ  <= '0;
            trigQ    <= 1'b0;
            clrQ     <= 1'b0;
            tickQ    <= 1'b0;
            latchQ   <= 1'b0;
            timeoutQ <= 1'b0;
            busyQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            timerQ   <= timerD;
            prescQ   <= prescD;
            cmQ      <= cmD;
            echoShQ  <= {echoShQ[1:0], bus.Echo};
            trigQ    <= trigD;
            clrQ     <= clrD;
            tickQ    <= tickD;
            latchQ   <= latchD;
            timeoutQ <= timeoutD;
            busyQ    <= busyD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        timerD   = timerQ;
        prescD   = prescQ;
        cmD      = cmQ;
        trigD    = 1'b0;
        clrD     = 1'b0;
        tickD    = 1'b0;
        latchD   = 1'b0;
        timeoutD = timeoutQ;
        busyD    = 1'b1;

        unique case (stateQ)
            StIdle: begin
                busyD = 1'b0;
                if (bus.Start || bus.Auto) begin
                    stateD   = StTrig;
                    timerD   = '0;
                    cmD      = '0;
                    trigD    = 1'b1;
                    clrD     = 1'b1;
                    timeoutD = 1'b0;
                    busyD    = 1'b1;
                end
            end
            StTrig: begin
                if (timerQ == TrigLast) begin
                    stateD = StWaitEcho;
                    timerD = '0;
                end else begin
                    trigD  = 1'b1;
                    timerD = timerQ + 1'b1;
                end
            end
            StWaitEcho: begin
                if (echoRise) begin
                    stateD = StMeasure;
                    prescD = '0;
                end else if (timerQ == TimeoutLast) begin
                    stateD   = StHoldoff;
                    timerD   = '0;
                    timeoutD = 1'b1;
                end else begin
                    timerD = timerQ + 1'b1;
                end
            end
            StMeasure: begin
                // A fall wins over both the pending tick and the over-range abort.
                if (echoFall) begin
                    stateD = StHoldoff;
                    timerD = '0;
                    latchD = 1'b1;
                end else if (cmQ == MaxCm) begin
                    stateD   = StHoldoff;
                    timerD   = '0;
                    timeoutD = 1'b1;
                end else begin
                    if (prescQ == TickDue) begin
                        tickD = 1'b1;
                        cmD   = cmQ + 9'd1;
                    end
                    prescD = (prescQ == PrescLast) ? '0 : prescQ + 1'b1;
                end
            end
            StHoldoff: begin
                if (timerQ == HoldoffLast) begin
                    stateD = StIdle;
                    busyD  = 1'b0;
                end else begin
                    timerD = timerQ + 1'b1;
                end
            end
            default: begin
                stateD = StIdle;
                busyD  = 1'b0;
            end
        endcase
    end

    assign bus.Trig    = trigQ;
    assign bus.CntClr  = clrQ;
    assign bus.CntTick = tickQ;
    assign bus.Latch   = latchQ;
    assign bus.Timeout = timeoutQ;
    assign bus.Busy    = busyQ;
    assign bus.Cm      = cmQ;
endmodule

// File: tb/tb_telemetre_ctrl.sv
// Bench for telemetre_ctrl: a timeline model of one measurement is compared with the
// outputs every cycle, plus fixed expectations for the directed scenarios.
module tb_telemetre_ctrl;
    localparam int unsigned TrigCycles    = 4;
    localparam int unsigned TickDiv       = 8;
    localparam int unsigned TimeoutCycles = 100;
    localparam int unsigned MaxCm         = 10;
    localparam int unsigned HoldoffCycles = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    telemetre_ctrl_if bus();

    telemetre_ctrl #(
        .TRIG_CYCLES   (TrigCycles),
        .TICK_DIV      (TickDiv),
        .TIMEOUT_CYCLES(TimeoutCycles),
        .MAX_CM        (MaxCm),
        .HOLDOFF_CYCLES(HoldoffCycles)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmpOn  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs, updated on every rising edge by the model below.
    bit     mTrig = 0, mClr = 0, mTick = 0, mLatch = 0, mTimeout = 0, mBusy = 0;
    int     mCm = 0;
    bit [3:0] hist = '0;  // pin samples, [0] newest
    bit     mRise = 0, mFall = 0;

    // One clock edge of the model; an edge with reset asserted aborts any measurement.
    task automatic nextEdge(output bit aborted);
        @(posedge clk);
        mClr   = 0;
        mTick  = 0;
        mLatch = 0;
        if (rst) begin
            mTrig = 0; mTimeout = 0; mBusy = 0; mCm = 0;
            hist = '0; mRise = 0; mFall = 0;
            aborted = 1;
        end else begin
            hist  = {hist[2:0], bus.Echo};
            // A pin change first sampled at edge j is acted upon at edge j+2.
            mRise = hist[2] && !hist[3];
            mFall = !hist[2] && hist[3];
            aborted = 0;
        end
    endtask

    task automatic runMeasurement();
        bit ab;
        bit got;
        bit done;
        int n;
        mTrig = 1; mClr = 1; mTimeout = 0; mCm = 0; mBusy = 1;
        for (int i = 0; i < int'(TrigCycles); i++) begin
            nextEdge(ab);
            if (ab) return;
        end
        mTrig = 0;
        got = 0;
        for (int i = 0; i < int'(TimeoutCycles) && !got; i++) begin
            nextEdge(ab);
            if (ab) return;
            if (mRise) got = 1;
        end
        if (!got) begin
            mTimeout = 1;
        end else begin
            n = 0;
            done = 0;
            while (!done) begin
                nextEdge(ab);
                if (ab) return;
                n++;
                if (mFall) begin
                    mLatch = 1;
                    done = 1;
                end else if (mCm == int'(MaxCm)) begin
                    mTimeout = 1;
                    done = 1;
                end else if (n % int'(TickDiv) == int'(TickDiv) - 1) begin
                    mTick = 1;
                    mCm++;
                end
            end
        end
        for (int i = 0; i < int'(HoldoffCycles); i++) begin
            nextEdge(ab);
            if (ab) return;
        end
        mBusy = 0;
    endtask

    initial begin : model
        bit ab;
        forever begin
            nextEdge(ab);
            if (!ab && (bus.Start === 1'b1 || bus.Auto === 1'b1)) runMeasurement();
        end
    end

    // Per-cycle comparison and event counters for the directed expectations.
    int cycN = 0, tickCnt = 0, latchCnt = 0, clrCnt = 0, trigCnt = 0, trigRises = 0;
    int cmAtLatch = 0, latchAt = 0, busyFallAt = 0, trigFallAt = 0, toAt = 0, tickAndLatch = 0;
    bit prevTrig = 0, prevBusy = 0, prevTimeout = 0;

    always @(negedge clk) begin
        if (cmpOn) begin
            check("Trig", bus.Trig, mTrig);
            check("CntClr", bus.CntClr, mClr);
            check("CntTick", bus.CntTick, mTick);
            check("Latch", bus.Latch, mLatch);
            check("Timeout", bus.Timeout, mTimeout);
            check("Busy", bus.Busy, mBusy);
            check("Cm", bus.Cm, mCm);
            cycN++;
            if (bus.CntTick) tickCnt++;
            if (bus.CntClr) clrCnt++;
            if (bus.Trig) trigCnt++;
            if (bus.Trig && !prevTrig) trigRises++;
            if (!bus.Trig && prevTrig) trigFallAt = cycN;
            if (bus.Timeout && !prevTimeout) toAt = cycN;
            if (!bus.Busy && prevBusy) busyFallAt = cycN;
            if (bus.CntTick && bus.Latch) tickAndLatch++;
            if (bus.Latch) begin
                latchCnt++;
                cmAtLatch = int'(bus.Cm);
                latchAt = cycN;
            end
            prevTrig = bus.Trig;
            prevBusy = bus.Busy;
            prevTimeout = bus.Timeout;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearCounters();
        tickCnt = 0; latchCnt = 0; clrCnt = 0; trigCnt = 0; trigRises = 0;
        cmAtLatch = -1; tickAndLatch = 0;
    endtask

    // Start pulse, then raise Echo 10 cycles after Trig has fallen.
    task automatic startAndRise();
        bus.Start = 1;
        cyc(1);
        bus.Start = 0;
        cyc(int'(TrigCycles) + 9);
        bus.Echo = 1;
    endtask

    initial begin : stim
        bus.Start = 0;
        bus.Auto  = 0;
        bus.Echo  = 0;
        rst = 1;
        cyc(3);
        cmpOn = 1;
        check("rst_busy", bus.Busy, 0);
        check("rst_cm", bus.Cm, 0);
        check("rst_trig", bus.Trig, 0);
        rst = 0;
        cyc(2);

        // Normal measurement
        clearCounters();
        startAndRise();
        cyc(40);
        bus.Echo = 0;
        cyc(40);
        check("norm_clr", clrCnt, 1);
        check("norm_trig_width", trigCnt, 4);
        check("norm_ticks", tickCnt, 5);
        check("norm_latch", latchCnt, 1);
        check("norm_cm", cmAtLatch, 5);
        check("norm_timeout", bus.Timeout, 0);
        check("norm_holdoff", busyFallAt - latchAt, 20);

        // No echo
        clearCounters();
        bus.Start = 1;
        cyc(1);
        bus.Start = 0;
        cyc(140);
        check("noecho_timeout", bus.Timeout, 1);
        check("noecho_delay", toAt - trigFallAt, 100);
        check("noecho_ticks", tickCnt, 0);
        check("noecho_latch", latchCnt, 0);
        cyc(10);
        check("noecho_sticky", bus.Timeout, 1);

        // Over-range
        clearCounters();
        bus.Start = 1;
        cyc(1);
        check("start_clears_timeout", bus.Timeout, 0);
        bus.Start = 0;
        cyc(int'(TrigCycles) + 8);
        bus.Echo = 1;
        cyc(200);
        bus.Echo = 0;
        cyc(10);
        check("over_ticks", tickCnt, 10);
        check("over_cm", bus.Cm, 10);
        check("over_timeout", bus.Timeout, 1);
        check("over_latch", latchCnt, 0);

        // Start during MEASURE is ignored and not queued
        clearCounters();
        startAndRise();
        cyc(20);
        bus.Start = 1;
        cyc(1);
        bus.Start = 0;
        cyc(9);
        bus.Echo = 0;
        cyc(30);
        check("busy_clr", clrCnt, 1);
        check("busy_cm", cmAtLatch, 3);
        check("busy_not_queued", bus.Busy, 0);

        // Auto retrigger after every holdoff
        clearCounters();
        bus.Auto = 1;
        cyc(400);
        bus.Auto = 0;
        cyc(140);
        check("auto_triggers", trigRises, 4);
        check("auto_clears", clrCnt, 4);

        // Reset mid-MEASURE after 3 ticks
        clearCounters();
        startAndRise();
        for (int i = 0; i < 100 && tickCnt < 3; i++) cyc(1);
        check("rstmid_ticks_seen", tickCnt, 3);
        rst = 1;
        cyc(1);
        rst = 0;
        check("rstmid_busy", bus.Busy, 0);
        check("rstmid_cm", bus.Cm, 0);
        check("rstmid_tick", bus.CntTick, 0);
        cyc(5);
        bus.Echo = 0;
        cyc(10);
        check("rstmid_no_latch", latchCnt, 0);

        // Fall on the cycle a tick is due
        clearCounters();
        startAndRise();
        cyc(39);
        bus.Echo = 0;
        cyc(30);
        check("wrap_latch", latchCnt, 1);
        check("wrap_cm", cmAtLatch, 4);
        check("wrap_no_tick", tickAndLatch, 0);

        // Fall exactly when Cm reaches MAX_CM
        clearCounters();
        startAndRise();
        cyc(80);
        bus.Echo = 0;
        cyc(30);
        check("max_latch", latchCnt, 1);
        check("max_cm", cmAtLatch, 10);
        check("max_timeout", bus.Timeout, 0);
        check("max_ticks", tickCnt, 10);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.Echo = ~bus.Echo;
            bus.Start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 299) == 0) bus.Auto = ~bus.Auto;
            rst = ($urandom_range(0, 699) == 0);
            cyc(1);
        end
        rst = 0;
        bus.Start = 0;
        bus.Auto = 0;
        bus.Echo = 0;
        cyc(160);
        check("final_idle", bus.Busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
